// File: rtl/psram_pkg.sv
// Shared definitions for the PSRAM arbiter: FSM encoding, strobe levels,
// default access timing and requester port IDs.
package psram_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        WRITE   = 2'd2,
        RECOVER = 2'd3
    } psramState_t;

    localparam logic STROBE_ON  = 1'b0;
    localparam logic STROBE_OFF = 1'b1;

    localparam int unsigned DEFAULT_ACCESS_CYCLES = 4;
    localparam int unsigned CNT_W                 = 4;

    localparam logic PORT_VID = 1'b0;
    localparam logic PORT_WR  = 1'b1;

endpackage

// File: rtl/psram_arb_pick.sv
// Grant selection between the video read and host write requesters.
// Fixed video-over-write priority, or round-robin when PSRAM_ARB_RR_EN is defined.
module psram_arb_pick
    import psram_pkg::*;
(
`ifdef PSRAM_ARB_RR_EN
    input  logic clk,
    input  logic resetn,
    input  logic accept,
`endif
    input  logic vidReq,
    input  logic wrReq,
    output logic grantVid,
    output logic grantWr
);

`ifdef PSRAM_ARB_RR_EN
    logic lastGrant;

    // Starts as "write" so that the first tie after reset goes to video.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lastGrant <= PORT_WR;
        end else if (accept && (vidReq || wrReq)) begin
            lastGrant <= grantWr ? PORT_WR : PORT_VID;
        end
    end

    always_comb begin
        grantVid = vidReq && (!wrReq || (lastGrant == PORT_WR));
        grantWr  = wrReq && !grantVid;
    end
`else
    always_comb begin
        grantVid = vidReq;
        grantWr  = wrReq && !vidReq;
    end
`endif

endmodule

// File: rtl/psram_arbiter.sv
// Single-word asynchronous PSRAM sequencer shared by a video read port and a host
// write port. Optional round-robin arbitration via PSRAM_ARB_RR_EN.
module psram_arbiter
    import psram_pkg::*;
#(
    parameter int unsigned ADDR_W        = 23,
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned ACCESS_CYCLES = DEFAULT_ACCESS_CYCLES
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_gnt,
    output logic              vid_valid,
    output logic [DATA_W-1:0] vid_rdata,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [1:0]        wr_be,
    output logic              wr_gnt,
    output logic              wr_done,
    output logic [ADDR_W-1:0] MemAdr,
    inout  logic [DATA_W-1:0] MemDB,
    output logic              MemOE,
    output logic              MemWR,
    output logic              RamCS,
    output logic              RamAdv,
    output logic              RamClk,
    output logic              RamCRE,
    output logic              RamLB,
    output logic              RamUB,
    input  logic              RamWait,
    output logic              FlashCS,
    output logic              FlashRp
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

    psramState_t       state, stateNxt;
    logic [CNT_W-1:0]  cnt, cntNxt;
    logic              grantVid, grantWr;

    logic [ADDR_W-1:0] adrNxt;
    logic [DATA_W-1:0] dbOut, dbOutNxt, rdataNxt;
    logic              dbOe, dbOeNxt;
    logic              oeNxt, wrNxt, csNxt, lbNxt, ubNxt;
    logic              vidGntNxt, vidValidNxt, wrGntNxt, wrDoneNxt;
    logic              unusedWait;

    assign unusedWait = RamWait;

    assign RamAdv  = 1'b0;
    assign RamClk  = 1'b0;
    assign RamCRE  = 1'b0;
    assign FlashCS = 1'b1;
    assign FlashRp = 1'b1;

    assign MemDB = dbOe ? dbOut : 'z;

    psram_arb_pick u_pick (
`ifdef PSRAM_ARB_RR_EN
        .clk      (clk),
        .resetn   (resetn),
        .accept   (state == IDLE),
`endif
        .vidReq   (vid_req),
        .wrReq    (wr_req),
        .grantVid (grantVid),
        .grantWr  (grantWr)
    );

    // State register; memory controls and handshake pulses are registered here too
    // so every pin changes on the clock edge and clears asynchronously on reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            MemAdr    <= '0;
            MemOE     <= STROBE_OFF;
            MemWR     <= STROBE_OFF;
            RamCS     <= STROBE_OFF;
            RamLB     <= STROBE_OFF;
            RamUB     <= STROBE_OFF;
            dbOe      <= 1'b0;
            dbOut     <= '0;
            vid_rdata <= '0;
            vid_gnt   <= 1'b0;
            vid_valid <= 1'b0;
            wr_gnt    <= 1'b0;
            wr_done   <= 1'b0;
        end else begin
            state     <= stateNxt;
            cnt       <= cntNxt;
            MemAdr    <= adrNxt;
            MemOE     <= oeNxt;
            MemWR     <= wrNxt;
            RamCS     <= csNxt;
            RamLB     <= lbNxt;
            RamUB     <= ubNxt;
            dbOe      <= dbOeNxt;
            dbOut     <= dbOutNxt;
            vid_rdata <= rdataNxt;
            vid_gnt   <= vidGntNxt;
            vid_valid <= vidValidNxt;
            wr_gnt    <= wrGntNxt;
            wr_done   <= wrDoneNxt;
        end
    end

    always_comb begin
        stateNxt = state;
        cntNxt   = cnt;
        case (state)
            IDLE: begin
                if (grantVid) begin
                    stateNxt = READ;
                    cntNxt   = CNT_LOAD;
                end else if (grantWr) begin
                    stateNxt = WRITE;
                    cntNxt   = CNT_LOAD;
                end
            end
            READ, WRITE: begin
                if (cnt == '0) begin
                    stateNxt = RECOVER;
                end else begin
                    cntNxt = cnt - 1'b1;
                end
            end
            RECOVER: stateNxt = IDLE;
            default: stateNxt = IDLE;
        endcase
    end

    always_comb begin
        adrNxt      = MemAdr;
        oeNxt       = MemOE;
        wrNxt       = MemWR;
        csNxt       = RamCS;
        lbNxt       = RamLB;
        ubNxt       = RamUB;
        dbOeNxt     = dbOe;
        dbOutNxt    = dbOut;
        rdataNxt    = vid_rdata;
        vidGntNxt   = 1'b0;
        vidValidNxt = 1'b0;
        wrGntNxt    = 1'b0;
        wrDoneNxt   = 1'b0;
        case (state)
            IDLE: begin
                if (grantVid) begin
                    adrNxt    = vid_addr;
                    csNxt     = STROBE_ON;
                    oeNxt     = STROBE_ON;
                    lbNxt     = STROBE_ON;
                    ubNxt     = STROBE_ON;
                    vidGntNxt = 1'b1;
                end else if (grantWr) begin
                    adrNxt   = wr_addr;
                    csNxt    = STROBE_ON;
                    wrNxt    = STROBE_ON;
                    lbNxt    = ~wr_be[0];
                    ubNxt    = ~wr_be[1];
                    dbOeNxt  = 1'b1;
                    dbOutNxt = wr_data;
                    wrGntNxt = 1'b1;
                end
            end
            READ: begin
                if (cnt == '0) begin
                    rdataNxt    = MemDB;
                    oeNxt       = STROBE_OFF;
                    csNxt       = STROBE_OFF;
                    lbNxt       = STROBE_OFF;
                    ubNxt       = STROBE_OFF;
                    vidValidNxt = 1'b1;
                end
            end
            WRITE: begin
                if (cnt == '0) begin
                    wrNxt     = STROBE_OFF;
                    csNxt     = STROBE_OFF;
                    lbNxt     = STROBE_OFF;
                    ubNxt     = STROBE_OFF;
                    wrDoneNxt = 1'b1;
                end
            end
            // Write data is held on the bus through this cycle, then released.
            RECOVER: dbOeNxt = 1'b0;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_psram_arbiter.sv
// Directed self-checking bench for psram_arbiter with a 16-word async PSRAM model
// (address bits [3:0] select the word). Honours PSRAM_ARB_RR_EN for the tie test.
`timescale 1ns/1ps
module tb_psram_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        vid_req;
    logic [22:0] vid_addr;
    logic        vid_gnt, vid_valid;
    logic [15:0] vid_rdata;
    logic        wr_req;
    logic [22:0] wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic        wr_gnt, wr_done;
    logic [22:0] MemAdr;
    wire  [15:0] memDB;
    logic        MemOE, MemWR, RamCS, RamAdv, RamClk, RamCRE, RamLB, RamUB;
    logic        RamWait;
    logic        FlashCS, FlashRp;

    int nCmp = 0;
    int nErr = 0;
    logic tieBad = 1'b0;

    logic [15:0] mem [16] = '{3: 16'hBEEF, 15: 16'hAAAA, default: 16'h0000};

    always #10 clk = ~clk;

    psram_arbiter #(.ADDR_W(23), .DATA_W(16), .ACCESS_CYCLES(4)) dut (
        .clk(clk), .resetn(resetn),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
        .vid_valid(vid_valid), .vid_rdata(vid_rdata),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .wr_gnt(wr_gnt), .wr_done(wr_done),
        .MemAdr(MemAdr), .MemDB(memDB), .MemOE(MemOE), .MemWR(MemWR), .RamCS(RamCS),
        .RamAdv(RamAdv), .RamClk(RamClk), .RamCRE(RamCRE), .RamLB(RamLB), .RamUB(RamUB),
        .RamWait(RamWait), .FlashCS(FlashCS), .FlashRp(FlashRp)
    );

    // Async RAM model: drives on OE+CS, writes enabled byte lanes while WE+CS low.
    assign memDB = (!RamCS && !MemOE && MemWR) ? mem[MemAdr[3:0]] : 'z;

    always @(negedge clk) begin
        if (resetn && !RamCS && !MemWR) begin
            if (!RamLB) mem[MemAdr[3:0]][7:0]  <= memDB[7:0];
            if (!RamUB) mem[MemAdr[3:0]][15:8] <= memDB[15:8];
        end
        if ({RamAdv, RamClk, RamCRE, FlashCS, FlashRp} !== 5'b00011) tieBad <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int oeLow, wrLow, dbCnt, doneCnt, doneAt, validCnt, validAt;
        int wrAt, g2At, gntCnt, lastValid, minGap, maxGap;
        logic g2Wr, expG2Wr;

        resetn = 1'b0; vid_req = 1'b0; vid_addr = '0; wr_req = 1'b0;
        wr_addr = '0; wr_data = '0; wr_be = '0; RamWait = 1'b0;
        repeat (3) tick();
        check("rst_strobes", 32'({MemOE, MemWR, RamCS, RamLB, RamUB}), 32'h1F);
        check("rst_adr", 32'(MemAdr), 32'h0);
        check("rst_db_z", 32'(memDB === 16'hzzzz), 32'd1);
        check("rst_pulses", 32'({vid_gnt, vid_valid, wr_gnt, wr_done}), 32'h0);
        check("rst_rdata", 32'(vid_rdata), 32'h0);
        resetn = 1'b1;
        tick();

        // Single read: strobes low in gnt cycle and 3 more; vid_valid lands in the
        // RECOVER cycle, 4 cycles after the gnt cycle (5 edges after sampling).
        vid_req = 1'b1; vid_addr = 23'h000123;
        tick();
        check("rd_gnt", 32'(vid_gnt), 32'd1);
        check("rd_adr", 32'(MemAdr), 32'h123);
        vid_req = 1'b0;
        oeLow = 0; validCnt = 0; validAt = -1;
        for (int k = 0; k < 8; k++) begin
            if (!MemOE && !RamCS) oeLow++;
            if (vid_valid) begin validCnt++; validAt = k; end
            tick();
        end
        check("rd_oe_low_cycles", 32'(oeLow), 32'd4);
        check("rd_valid_at", 32'(validAt), 32'd4);
        check("rd_valid_cnt", 32'(validCnt), 32'd1);
        check("rd_data", 32'(vid_rdata), 32'hBEEF);

        // Single write to the top address, upper byte only.
        wr_req = 1'b1; wr_addr = 23'h7FFFFF; wr_data = 16'h1234; wr_be = 2'b10;
        tick();
        check("wr_gnt", 32'(wr_gnt), 32'd1);
        check("wr_lanes", 32'({RamUB, RamLB}), 32'b01);
        check("wr_adr", 32'(MemAdr), 32'h7FFFFF);
        wr_req = 1'b0;
        wrLow = 0; dbCnt = 0; doneCnt = 0; doneAt = -1;
        for (int k = 0; k < 8; k++) begin
            if (!MemWR && !RamCS) wrLow++;
            if (memDB === 16'h1234) dbCnt++;
            if (wr_done) begin doneCnt++; doneAt = k; end
            tick();
        end
        check("wr_we_low_cycles", 32'(wrLow), 32'd4);
        check("wr_db_cycles", 32'(dbCnt), 32'd5);
        check("wr_done_at", 32'(doneAt), 32'd4);
        check("wr_done_cnt", 32'(doneCnt), 32'd1);
        check("wr_mem_upper", 32'(mem[15]), 32'h12AA);
        check("wr_db_released", 32'(memDB === 16'hzzzz), 32'd1);

        // Simultaneous requests: video first, write 6 cycles later.
        vid_req = 1'b1; vid_addr = 23'h7FFFFF;
        wr_req = 1'b1; wr_addr = 23'h000005; wr_data = 16'h5555; wr_be = 2'b11;
        tick();
        check("tie_vid_first", 32'({vid_gnt, wr_gnt}), 32'b10);
        vid_req = 1'b0;
        wrAt = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (wr_gnt && wrAt < 0) begin wrAt = k; wr_req = 1'b0; end
        end
        wr_req = 1'b0;
        check("tie_wr_delay", 32'(wrAt), 32'd6);
        check("tie_rd_data", 32'(vid_rdata), 32'h12AA);
        check("tie_wr_mem", 32'(mem[5]), 32'h5555);

        // Two back-to-back ties: both requesters keep asking.
`ifdef PSRAM_ARB_RR_EN
        expG2Wr = 1'b1;
`else
        expG2Wr = 1'b0;
`endif
        vid_req = 1'b1; vid_addr = 23'h000003;
        wr_req = 1'b1; wr_addr = 23'h000006; wr_data = 16'h6666; wr_be = 2'b11;
        tick();
        check("tie1_grant", 32'({vid_gnt, wr_gnt}), 32'b10);
        g2At = -1; g2Wr = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (g2At < 0 && (vid_gnt || wr_gnt)) begin
                g2At = k; g2Wr = wr_gnt; vid_req = 1'b0;
                if (wr_gnt) wr_req = 1'b0;
            end
        end
        vid_req = 1'b0;
        check("tie2_delay", 32'(g2At), 32'd6);
        check("tie2_port", 32'(g2Wr), 32'(expG2Wr));
        gntCnt = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (wr_gnt) begin gntCnt++; wr_req = 1'b0; end
        end
        wr_req = 1'b0;
        check("tie_wr_served", 32'(gntCnt + 32'(g2Wr)), 32'd1);

        // Reset two cycles into a write.
        wr_req = 1'b1; wr_addr = 23'h000010; wr_data = 16'hA5A5; wr_be = 2'b11;
        tick();
        check("rst_wr_gnt", 32'(wr_gnt), 32'd1);
        wr_req = 1'b0;
        tick(); tick();
        check("rst_wr_active", 32'({MemWR, RamCS}), 32'b00);
        resetn = 1'b0;
        #0.001;
        check("rst_async_strobes", 32'({MemOE, MemWR, RamCS, RamLB, RamUB}), 32'h1F);
        check("rst_async_db_z", 32'(memDB === 16'hzzzz), 32'd1);
        doneCnt = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (wr_done) doneCnt++;
        end
        resetn = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (wr_done) doneCnt++;
        end
        check("rst_no_done", 32'(doneCnt), 32'd0);
        vid_req = 1'b1; vid_addr = 23'h000003;
        tick();
        check("rst_fresh_gnt", 32'(vid_gnt), 32'd1);
        vid_req = 1'b0;
        validAt = -1;
        for (int k = 0; k < 8; k++) begin
            if (vid_valid) validAt = k;
            tick();
        end
        check("rst_fresh_valid_at", 32'(validAt), 32'd4);
        check("rst_fresh_data", 32'(vid_rdata), 32'hBEEF);

        // Write request withdrawn during a read is never granted.
        vid_req = 1'b1; vid_addr = 23'h000003;
        tick();
        vid_req = 1'b0;
        gntCnt = 0;
        for (int k = 1; k <= 12; k++) begin
            if (k == 1) begin wr_req = 1'b1; wr_addr = 23'h000007; end
            if (k == 3) wr_req = 1'b0;
            tick();
            if (wr_gnt) gntCnt++;
        end
        check("withdrawn_no_gnt", 32'(gntCnt), 32'd0);

        // Write with no byte enables still runs and completes.
        wr_req = 1'b1; wr_addr = 23'h000002; wr_data = 16'hFFFF; wr_be = 2'b00;
        tick();
        check("be00_gnt", 32'(wr_gnt), 32'd1);
        check("be00_lanes", 32'({RamUB, RamLB}), 32'b11);
        wr_req = 1'b0;
        doneCnt = 0;
        for (int k = 0; k < 8; k++) begin
            if (wr_done) doneCnt++;
            tick();
        end
        check("be00_done_cnt", 32'(doneCnt), 32'd1);
        check("be00_mem_kept", 32'(mem[2]), 32'h0000);

        // Continuous video requests for 100 cycles.
        vid_req = 1'b1; vid_addr = 23'h000003;
        validCnt = 0; lastValid = -1; minGap = 1000; maxGap = 0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (vid_valid) begin
                validCnt++;
                if (lastValid >= 0) begin
                    if (i - lastValid < minGap) minGap = i - lastValid;
                    if (i - lastValid > maxGap) maxGap = i - lastValid;
                end
                lastValid = i;
            end
        end
        vid_req = 1'b0;
        check("cont_reads", 32'(validCnt), 32'd16);
        check("cont_min_gap", 32'(minGap), 32'd6);
        check("cont_max_gap", 32'(maxGap), 32'd6);
        check("tie_offs", 32'(tieBad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
